// File: rtl/anc_pkg.sv
// Shared definitions for the ANC signal path: Q1.15 sample format and FIR state encoding.
package anc_pkg;

    localparam int Q_FRAC   = 15;
    localparam int SAMPLE_W = 16;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } fir_state_t;

endpackage

// File: rtl/round_sat_q15.sv
// Round-half-up and saturate a wide Q.15 accumulator down to a Q1.15 sample.
module round_sat_q15
    import anc_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] result,
    output logic                       sat
);

    localparam logic signed [ACC_W-1:0] HALF_LSB =
        {{(ACC_W-Q_FRAC){1'b0}}, 1'b1, {(Q_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-SAMPLE_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] R_MIN = {{(ACC_W-SAMPLE_W){1'b1}}, SAT_MIN};

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;

    // add half an output LSB, shift down, then clip to the 16-bit range
    always_comb begin
        biased  = acc + HALF_LSB;
        shifted = biased >>> Q_FRAC;
        result  = shifted[SAMPLE_W-1:0];
        sat     = 1'b0;
        if (shifted > R_MAX) begin
            result = SAT_MAX;
            sat    = 1'b1;
        end else if (shifted < R_MIN) begin
            result = SAT_MIN;
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_16bit.sv
// Time-multiplexed direct-form FIR: one MAC per cycle over N_TAPS taps, then round/saturate.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a sample; coefficient writes honoured here only
//   MAC   | one tap accumulated per cycle, N_TAPS cycles
//   ROUND | rounded/saturated result presented with out_valid for 1 cycle
module fir_mac_16bit
    import anc_pkg::*;
#(
    parameter int N_TAPS = 16,
    parameter int ADDR_W = 6,
    parameter int ACC_W  = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [15:0]         in1,
    output logic                in_ready,
    input  logic                coef_we,
    input  logic [ADDR_W-1:0]   coef_addr,
    input  logic [15:0]         coef_data,
    output logic                out_valid,
    output logic [15:0]         out1,
    output logic                out_sat,
    output logic                coef_err
);

    localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(N_TAPS - 1);
    localparam logic [ADDR_W:0]   TAP_LIMIT = (ADDR_W+1)'(N_TAPS);

    fir_state_t state, next_state;

    logic signed [SAMPLE_W-1:0]   x [N_TAPS];
    logic signed [SAMPLE_W-1:0]   c [N_TAPS];
    logic [TAP_W-1:0]             tap;
    logic signed [ACC_W-1:0]      acc;
    logic signed [2*SAMPLE_W-1:0] prod;

    logic signed [SAMPLE_W-1:0]   rs_result;
    logic                         rs_sat;
    logic [15:0]                  hold_out;
    logic                         hold_sat;

    logic accept;
    logic addr_ok;
    logic coef_ok;
    logic coef_bad;

    assign accept   = (state == IDLE) && in_valid;
    assign addr_ok  = ({1'b0, coef_addr} < TAP_LIMIT);
    assign coef_ok  = coef_we && (state == IDLE) && addr_ok;
    assign coef_bad = coef_we && !((state == IDLE) && addr_ok);
    assign prod     = 32'(x[tap]) * 32'(c[tap]);

    round_sat_q15 #(.ACC_W(ACC_W)) u_round_sat (
        .acc    (acc),
        .result (rs_result),
        .sat    (rs_sat)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = MAC;
            MAC:     if (tap == LAST_TAP) next_state = ROUND;
            ROUND:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // outputs: ready in IDLE, fresh result straight from the rounder in ROUND, held otherwise
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == ROUND);
        out1      = hold_out;
        out_sat   = hold_sat;
        if (state == ROUND) begin
            out1    = rs_result;
            out_sat = rs_sat;
        end
    end

    // delay line shifts once per accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
        end else if (accept) begin
            x[0] <= in1;
            for (int k = 1; k < N_TAPS; k++) x[k] <= x[k-1];
        end
    end

    // coefficient storage; a write in the accept cycle is visible to the first MAC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) c[k] <= '0;
        end else if (coef_ok) begin
            c[coef_addr[TAP_W-1:0]] <= coef_data;
        end
    end

    // sticky flag for writes outside IDLE or beyond the last tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           coef_err <= 1'b0;
        else if (coef_bad) coef_err <= 1'b1;
    end

    // accumulator and tap index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            tap <= '0;
        end else if (accept) begin
            acc <= '0;
            tap <= '0;
        end else if (state == MAC) begin
            acc <= acc + ACC_W'(prod);
            if (tap != LAST_TAP) tap <= tap + 1'b1;
        end
    end

    // capture the result so it persists after the out_valid cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_out <= '0;
            hold_sat <= 1'b0;
        end else if (state == ROUND) begin
            hold_out <= rs_result;
            hold_sat <= rs_sat;
        end
    end

endmodule

// File: doc/fir_mac_16bit.md
Name: fir_mac_16bit

Overview:
Time-multiplexed direct-form FIR filter for the ANC signal path. It accepts one signed 16-bit Q1.15 sample at a time and runs one multiply-accumulate per cycle over N taps. It then rounds and saturates the sum and emits one 16-bit Q1.15 sample to the downstream gain stage (Multiply_1_16bit-class blocks on in1). Coefficients are loaded at run time through a simple write port.

Parameters:
N_TAPS, 16, number of filter taps (2..64)
ADDR_W, 6, coefficient address width; must satisfy 2**ADDR_W >= N_TAPS
ACC_W, 40, accumulator width; must be >= 32 + ceil(log2(N_TAPS))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  sample present on in1
in1  in  16  signed Q1.15 input sample
in_ready  out  1  block can accept a sample this cycle
coef_we  in  1  coefficient write strobe
coef_addr  in  ADDR_W  tap index to write
coef_data  in  16  signed Q1.15 coefficient
out_valid  out  1  one-cycle pulse; out1 holds a new result
out1  out  16  signed Q1.15 filtered sample
out_sat  out  1  qualified by out_valid; result was clipped
coef_err  out  1  sticky: a write was rejected

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out1=0, out_sat=0, coef_err=0. Delay line, coefficient RAM, accumulator and tap counter are all cleared to 0. FSM goes to IDLE.
- FSM states: IDLE, MAC, ROUND.
- IDLE:
  - in_ready=1.
  - On in_valid, the sample is accepted in that cycle: the delay line shifts (x[0]<=in1, x[k]<=x[k-1]), acc<=0, tap<=0, go to MAC.
- MAC:
  - in_ready=0.
  - Each cycle: acc += sext(x[tap]*c[tap]), where the product is a full 32-bit signed value. Then tap++.
  - When tap==N_TAPS-1 has been accumulated, go to ROUND.
  - MAC lasts exactly N_TAPS cycles.
- ROUND:
  - r = (acc + 2^14) >>> 15, arithmetic shift, round half up.
  - If r > 32767: out1=32767, out_sat=1. If r < -32768: out1=-32768, out_sat=1. Otherwise out1=r[15:0], out_sat=0.
  - out_valid=1 for exactly this one cycle, then go to IDLE.
- Latency: the accept edge is cycle 0; out_valid is asserted in cycle N_TAPS+1.
- Throughput: one sample per N_TAPS+2 cycles.
- out1 and out_sat hold their values until the next ROUND.
- in_valid while in_ready=0 is ignored. The upstream source must hold the sample until it is accepted; no sample is dropped silently.
- Coefficient writes:
  - Honoured only in IDLE, including a cycle that also accepts a sample. In that case the write lands before the first MAC cycle and is used for this sample.
  - coef_we in MAC or ROUND is discarded and sets coef_err.
  - coef_addr >= N_TAPS is discarded and sets coef_err.
  - coef_err is cleared only by rst.
- Corner product: (-32768)*(-32768) = 2^30 is represented exactly in 32 bits. A single tap of this kind rounds to 32768, so it saturates to 32767.
- Accumulator overflow is impossible for the specified ACC_W.
- Reset mid-operation (rst in MAC or ROUND): the result is abandoned with no out_valid pulse. All state returns to reset values, including the coefficients.

Decomposition:
- Shared package anc_pkg holds:
  - Q1.15 constants: Q_FRAC=15, SAMPLE_W=16, SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000.
  - The FSM state enum for IDLE, MAC and ROUND.
- One natural sub-module: round_sat_q15. It is combinational, ACC_W in and 16 bits out plus a sat flag, and is reused by later ANC stages.

Test Plan:
- Identity: c[0]=0x7FFF, others 0; input 1000 -> out1=1000, out_sat=0, out_valid exactly N_TAPS+1 cycles after accept.
- Impulse: c[0..2]=0x4000,0x2000,0x1000; inputs 0x4000,0,0,0 -> out1 = 0x2000, 0x1000, 0x0800, 0x0000.
- Saturation: all c=0x7FFF, N_TAPS=4; four inputs of 0x7FFF -> 4th output 0x7FFF with out_sat=1. Repeat with input 0x8000 and c=0x8000 on tap 0 only -> 0x7FFF, out_sat=1.
- Handshake: hold in_valid high continuously -> samples accepted only on IDLE cycles, spacing N_TAPS+2. coef_we during MAC -> coef_err=1 and coefficients unchanged.
- Reset mid-MAC: assert rst at MAC tap 5 -> out_valid never pulses, out1=0, in_ready=1 immediately. The next input with zero coefficients gives out1=0.
